// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle for the hazard/stall controller: ID/EX hazard inputs,
// MUL/DIV handshake, register enable/flush controls and performance counters.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_Rs1;
    logic [4:0]       ID_Rs2;
    logic             ID_UseRs1;
    logic             ID_UseRs2;
    logic [4:0]       EX_Rd;
    logic             EX_MemRead;
    logic             EX_BranchTaken;
    logic             EX_MulDiv;
    logic             MD_Done;
    logic             Cnt_Clear;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             EXMEM_Flush;
    logic             MD_Start;
    logic             MD_Timeout;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Flush_Count;

    // The controller sits on the slave side; the pipeline drives the hazard inputs.
    modport slave (
        input  ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, EX_Rd, EX_MemRead,
               EX_BranchTaken, EX_MulDiv, MD_Done, Cnt_Clear,
        output PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush,
               EXMEM_Flush, MD_Start, MD_Timeout, Stall_Count, Flush_Count
    );

    modport master (
        output ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, EX_Rd, EX_MemRead,
               EX_BranchTaken, EX_MulDiv, MD_Done, Cnt_Clear,
        input  PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush,
               EXMEM_Flush, MD_Start, MD_Timeout, Stall_Count, Flush_Count
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, taken-branch
// flushes and MUL/DIV occupancy of EX with a timeout release.
module hazard_stall_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    hazard_stall_controller_if.slave  bus
);
    localparam int WCNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t           state_q, next_state;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_q, flush_q;

    logic pc_write, ifid_write, idex_write;
    logic ifid_flush, idex_flush, exmem_flush;
    logic md_start, md_timeout, flush_evt, load_use;

    assign load_use = bus.EX_MemRead && (bus.EX_Rd != 5'd0) &&
                      ((bus.ID_UseRs1 && (bus.ID_Rs1 == bus.EX_Rd)) ||
                       (bus.ID_UseRs2 && (bus.ID_Rs2 == bus.EX_Rd)));

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_start    = 1'b0;
        md_timeout  = 1'b0;
        flush_evt   = 1'b0;
        next_state  = state_q;
        wcnt_d      = wcnt_q;

        if (rst) begin
            // Freeze and bubble the front end; any in-flight MUL/DIV is abandoned.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            next_state  = RUN;
            wcnt_d      = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.EX_BranchTaken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_evt  = 1'b1;
                    end else if (bus.EX_MulDiv) begin
                        md_start    = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_flush = 1'b1;
                        next_state  = MD_WAIT;
                        wcnt_d      = '0;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (bus.MD_Done) begin
                        next_state = RUN;
                    end else if (wcnt_q == WCNT_LAST) begin
                        // Forced release: pipeline advances but the op's result is dropped.
                        md_timeout  = 1'b1;
                        exmem_flush = 1'b1;
                        next_state  = RUN;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_flush = 1'b1;
                        wcnt_d      = wcnt_q + WCNT_W'(1);
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= next_state;
            wcnt_q  <= wcnt_d;
            if (bus.Cnt_Clear) begin
                stall_q <= '0;
                flush_q <= '0;
            end else begin
                if (!pc_write && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
                if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.PC_Write    = pc_write;
    assign bus.IFID_Write  = ifid_write;
    assign bus.IDEX_Write  = idex_write;
    assign bus.IFID_Flush  = ifid_flush;
    assign bus.IDEX_Flush  = idex_flush;
    assign bus.EXMEM_Flush = exmem_flush;
    assign bus.MD_Start    = md_start;
    assign bus.MD_Timeout  = md_timeout;
    assign bus.Stall_Count = stall_q;
    assign bus.Flush_Count = flush_q;
endmodule
